idex_latch: RTL and testbench
=============================

IDEX_LATCH -- requirements
Module: idex_latch

Interface
REQ-001 SHALL have parameter STALL_W, default 16, giving the width of the stall counter.
REQ-002 SHALL have port CLK, input, 1, clock; all state updates on the rising edge.
REQ-003 SHALL have port RST, input, 1, reset; one clock, synchronous, active-high.
REQ-004 SHALL have ports IDEX_enable and IDEX_flush, input, 1 each, advance and flush commands from the hazard unit.
REQ-005 SHALL have ports id_valid, input, 1 (ID holds a real instruction), and id_pc, id_instr, id_rdat1, id_rdat2, id_imm, input, 32 each (ID-stage values).
REQ-006 SHALL have ports id_rs, id_rt, id_wsel, input, 5 each (ID register selects), and id_op, input, 6 (ID opcode).
REQ-007 SHALL have ports id_RegWr, id_MemRead, id_MemWrite, id_jump, input, 1 each (ID control bits).
REQ-008 SHALL have outputs ex_valid, 1; ex_pc, ex_instr, ex_rdat1, ex_rdat2, ex_imm, 32 each; ex_wsel, 5; ex_RegWr, ex_MemRead, ex_MemWrite, 1 each (EX-stage copies).
REQ-009 SHALL have outputs IDEX_Rs and IDEX_Rt, 5 each, and ex_op, 6; these feed hazard unit forwarding and optimisation.
REQ-010 SHALL have output JumpFlush, 1, a jump-resolved pulse to the hazard unit.
REQ-011 SHALL have output stall_cnt, STALL_W bits, the count of cycles a valid instruction was held in EX.

Function
REQ-012 SHALL update state each edge with priority RST > IDEX_flush > IDEX_enable > hold.
REQ-013 SHALL, on flush, load a bubble: ex_valid, ex_RegWr, ex_MemRead, ex_MemWrite and the internal jump bit = 0; ex_op = 6'h00; all 32-bit and 5-bit fields = 0.
REQ-014 SHALL, on enable without flush, capture every id_* input into its ex_* or IDEX_* counterpart with a latency of exactly one cycle.
REQ-015 SHALL, on enable when id_valid = 0, capture the bubble values of REQ-013, whatever the other id_* inputs hold.
REQ-016 SHALL, on hold (enable = 0, flush = 0), keep every output unchanged except JumpFlush and stall_cnt.
REQ-017 SHALL keep a one-bit fired flag: set when JumpFlush is asserted, cleared whenever a new entry is loaded (enable or flush).
REQ-018 SHALL drive JumpFlush = ex_valid AND jump bit AND NOT fired, so a held jump pulses exactly once, in its first EX cycle.
REQ-019 SHALL increment stall_cnt on each edge where ex_valid = 1, enable = 0 and flush = 0, saturating at 2^STALL_W-1 with no wrap.
REQ-020 SHALL take flush when flush and enable are asserted together, and SHALL NOT count that cycle as a stall.

Reset
REQ-021 SHALL, on RST = 1 at an edge, load the bubble of REQ-013, clear fired and stall_cnt to 0, and deassert JumpFlush the following cycle, including mid-stall or mid-jump.
REQ-022 SHALL ignore IDEX_enable and IDEX_flush in any cycle with RST = 1.

Verification
REQ-023 Advance: id_valid = 1, id_pc = 0x0000_0040, id_rs = 5, id_rt = 9, id_op = 6'h23, enable = 1 for one edge -> next cycle ex_pc = 0x40, IDEX_Rs = 5, IDEX_Rt = 9, ex_op = 6'h23, ex_valid = 1.
REQ-024 Flush priority: flush = 1 and enable = 1 with id_RegWr = 1 -> next cycle ex_valid = 0, ex_RegWr = 0, ex_op = 0, stall_cnt unchanged.
REQ-025 Held jump: load id_jump = 1, id_valid = 1, then hold for 3 cycles -> JumpFlush high for the first cycle only, and stall_cnt = 3 after the hold.
REQ-026 Saturation: STALL_W = 4, valid entry held for 20 cycles -> stall_cnt stops at 15.
REQ-027 Reset mid-stall: stall_cnt = 7 with a jump in EX, RST pulsed for one edge -> ex_valid = 0, stall_cnt = 0, JumpFlush = 0, and the next enable loads normally.
REQ-028 Invalid advance: id_valid = 0, id_MemWrite = 1, enable = 1 -> ex_MemWrite = 0, ex_valid = 0.

Source files
------------

// File: rtl/idex_latch.sv
// ID/EX pipeline latch with bubble insertion, one-shot jump
// resolution pulse and a saturating held-in-EX stall counter.
module idex_latch #(
  parameter int STALL_W = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               IDEX_enable,
  input  logic               IDEX_flush,
  input  logic               id_valid,
  input  logic [31:0]        id_pc,
  input  logic [31:0]        id_instr,
  input  logic [31:0]        id_rdat1,
  input  logic [31:0]        id_rdat2,
  input  logic [31:0]        id_imm,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic [4:0]         id_wsel,
  input  logic [5:0]         id_op,
  input  logic               id_RegWr,
  input  logic               id_MemRead,
  input  logic               id_MemWrite,
  input  logic               id_jump,
  output logic               ex_valid,
  output logic [31:0]        ex_pc,
  output logic [31:0]        ex_instr,
  output logic [31:0]        ex_rdat1,
  output logic [31:0]        ex_rdat2,
  output logic [31:0]        ex_imm,
  output logic [4:0]         ex_wsel,
  output logic               ex_RegWr,
  output logic               ex_MemRead,
  output logic               ex_MemWrite,
  output logic [4:0]         IDEX_Rs,
  output logic [4:0]         IDEX_Rt,
  output logic [5:0]         ex_op,
  output logic               JumpFlush,
  output logic [STALL_W-1:0] stall_cnt
);

  logic exJump;
  logic fired;
  logic doLoad;
  logic loadReal;
  logic isHold;
  logic stallSat;

  // A new entry arrives on reset, flush or enable; only an
  // un-flushed, valid enable outside reset brings real contents.
  always_comb begin
    doLoad   = RST | IDEX_flush | IDEX_enable;
    loadReal = ~RST & ~IDEX_flush & IDEX_enable & id_valid;
    isHold   = ~doLoad;
    stallSat = &stall_cnt;
  end

  // Pulse only in the first cycle a jump sits in EX.
  assign JumpFlush = ex_valid & exJump & ~fired;

  // Entry register: capture ID values or a zeroed bubble.
  always_ff @(posedge CLK) begin
    if (doLoad) begin
      if (loadReal) begin
        ex_valid    <= 1'b1;
        ex_pc       <= id_pc;
        ex_instr    <= id_instr;
        ex_rdat1    <= id_rdat1;
        ex_rdat2    <= id_rdat2;
        ex_imm      <= id_imm;
        ex_wsel     <= id_wsel;
        ex_RegWr    <= id_RegWr;
        ex_MemRead  <= id_MemRead;
        ex_MemWrite <= id_MemWrite;
        IDEX_Rs     <= id_rs;
        IDEX_Rt     <= id_rt;
        ex_op       <= id_op;
        exJump      <= id_jump;
      end else begin
        ex_valid    <= 1'b0;
        ex_pc       <= '0;
        ex_instr    <= '0;
        ex_rdat1    <= '0;
        ex_rdat2    <= '0;
        ex_imm      <= '0;
        ex_wsel     <= '0;
        ex_RegWr    <= 1'b0;
        ex_MemRead  <= 1'b0;
        ex_MemWrite <= 1'b0;
        IDEX_Rs     <= '0;
        IDEX_Rt     <= '0;
        ex_op       <= '0;
        exJump      <= 1'b0;
      end
    end
  end

  // Fired flag remembers a pulse until the next entry loads.
  always_ff @(posedge CLK) begin
    if (doLoad) begin
      fired <= 1'b0;
    end else begin
      fired <= fired | JumpFlush;
    end
  end

  // Count held valid cycles, saturating; flush+enable is no stall.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
    end else if (isHold && ex_valid && !stallSat) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_idex_latch.sv
// Directed bench for idex_latch: advance, flush, bubble,
// one-shot jump pulse, stall counting, saturation and reset.
module tb_idex_latch;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IDEX_enable;
  logic        IDEX_flush;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [31:0] id_rdat1;
  logic [31:0] id_rdat2;
  logic [31:0] id_imm;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_wsel;
  logic [5:0]  id_op;
  logic        id_RegWr;
  logic        id_MemRead;
  logic        id_MemWrite;
  logic        id_jump;

  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_instr;
  logic [31:0] ex_rdat1;
  logic [31:0] ex_rdat2;
  logic [31:0] ex_imm;
  logic [4:0]  ex_wsel;
  logic        ex_RegWr;
  logic        ex_MemRead;
  logic        ex_MemWrite;
  logic [4:0]  IDEX_Rs;
  logic [4:0]  IDEX_Rt;
  logic [5:0]  ex_op;
  logic        JumpFlush;
  logic [15:0] stall_cnt;

  logic        sValid;
  logic [31:0] sPc;
  logic [31:0] sInstr;
  logic [31:0] sRdat1;
  logic [31:0] sRdat2;
  logic [31:0] sImm;
  logic [4:0]  sWsel;
  logic        sRegWr;
  logic        sMemRead;
  logic        sMemWrite;
  logic [4:0]  sRs;
  logic [4:0]  sRt;
  logic [5:0]  sOp;
  logic        sJumpFlush;
  logic [3:0]  sStall;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  idex_latch dut (
    .CLK(CLK), .RST(RST),
    .IDEX_enable(IDEX_enable), .IDEX_flush(IDEX_flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .id_rdat1(id_rdat1), .id_rdat2(id_rdat2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_wsel(id_wsel),
    .id_op(id_op), .id_RegWr(id_RegWr),
    .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .id_jump(id_jump),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr),
    .ex_rdat1(ex_rdat1), .ex_rdat2(ex_rdat2), .ex_imm(ex_imm),
    .ex_wsel(ex_wsel), .ex_RegWr(ex_RegWr),
    .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .IDEX_Rs(IDEX_Rs), .IDEX_Rt(IDEX_Rt), .ex_op(ex_op),
    .JumpFlush(JumpFlush), .stall_cnt(stall_cnt)
  );

  idex_latch #(.STALL_W(4)) dutSmall (
    .CLK(CLK), .RST(RST),
    .IDEX_enable(IDEX_enable), .IDEX_flush(IDEX_flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .id_rdat1(id_rdat1), .id_rdat2(id_rdat2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_wsel(id_wsel),
    .id_op(id_op), .id_RegWr(id_RegWr),
    .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .id_jump(id_jump),
    .ex_valid(sValid), .ex_pc(sPc), .ex_instr(sInstr),
    .ex_rdat1(sRdat1), .ex_rdat2(sRdat2), .ex_imm(sImm),
    .ex_wsel(sWsel), .ex_RegWr(sRegWr),
    .ex_MemRead(sMemRead), .ex_MemWrite(sMemWrite),
    .IDEX_Rs(sRs), .IDEX_Rt(sRt), .ex_op(sOp),
    .JumpFlush(sJumpFlush), .stall_cnt(sStall)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clrIn();
    RST = 1'b0; IDEX_enable = 1'b0; IDEX_flush = 1'b0;
    id_valid = 1'b0; id_pc = '0; id_instr = '0;
    id_rdat1 = '0; id_rdat2 = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_wsel = '0; id_op = '0;
    id_RegWr = 1'b0; id_MemRead = 1'b0;
    id_MemWrite = 1'b0; id_jump = 1'b0;
  endtask

  initial begin
    clrIn();
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_pc", ex_pc, 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_jf", 32'(JumpFlush), 32'd0);

    // advance
    id_valid = 1'b1; id_pc = 32'h40; id_rs = 5'd5;
    id_rt = 5'd9; id_op = 6'h23; id_instr = 32'h8C22_0004;
    id_rdat1 = 32'h1111_2222; id_rdat2 = 32'h3333_4444;
    id_imm = 32'hFFFF_FFFC; id_wsel = 5'd2;
    id_RegWr = 1'b1; id_MemRead = 1'b1;
    IDEX_enable = 1'b1;
    step();
    clrIn();
    chk("adv_pc", ex_pc, 32'h40);
    chk("adv_rs", 32'(IDEX_Rs), 32'd5);
    chk("adv_rt", 32'(IDEX_Rt), 32'd9);
    chk("adv_op", 32'(ex_op), 32'h23);
    chk("adv_valid", 32'(ex_valid), 32'd1);
    chk("adv_instr", ex_instr, 32'h8C22_0004);
    chk("adv_rd1", ex_rdat1, 32'h1111_2222);
    chk("adv_rd2", ex_rdat2, 32'h3333_4444);
    chk("adv_imm", ex_imm, 32'hFFFF_FFFC);
    chk("adv_wsel", 32'(ex_wsel), 32'd2);
    chk("adv_ctl", {29'd0, ex_RegWr, ex_MemRead, ex_MemWrite},
        32'b110);
    chk("adv_stall", 32'(stall_cnt), 32'd0);

    // hold two cycles with changing ID inputs
    id_pc = 32'hDEAD_BEEF; id_op = 6'h3F; id_valid = 1'b1;
    step();
    step();
    chk("hold_pc", ex_pc, 32'h40);
    chk("hold_op", 32'(ex_op), 32'h23);
    chk("hold_stall", 32'(stall_cnt), 32'd2);

    // flush wins over enable, no stall counted
    IDEX_flush = 1'b1; IDEX_enable = 1'b1; id_RegWr = 1'b1;
    id_valid = 1'b1; id_pc = 32'h44;
    step();
    clrIn();
    chk("fl_valid", 32'(ex_valid), 32'd0);
    chk("fl_regwr", 32'(ex_RegWr), 32'd0);
    chk("fl_op", 32'(ex_op), 32'd0);
    chk("fl_pc", ex_pc, 32'd0);
    chk("fl_stall", 32'(stall_cnt), 32'd2);

    // bubble held does not count
    step();
    chk("bub_stall", 32'(stall_cnt), 32'd2);

    // held jump
    RST = 1'b1;
    step();
    RST = 1'b0;
    id_valid = 1'b1; id_jump = 1'b1; id_pc = 32'h60;
    IDEX_enable = 1'b1;
    step();
    clrIn();
    chk("jmp_first", 32'(JumpFlush), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("jmp_hold", 32'(JumpFlush), 32'd0);
    end
    chk("jmp_stall", 32'(stall_cnt), 32'd3);

    // reset mid-stall with jump in EX; enable is ignored
    for (int i = 0; i < 4; i++) step();
    chk("pre_rst_stall", 32'(stall_cnt), 32'd7);
    RST = 1'b1; IDEX_enable = 1'b1; id_valid = 1'b1;
    id_pc = 32'h70; id_jump = 1'b1;
    step();
    clrIn();
    chk("mrst_valid", 32'(ex_valid), 32'd0);
    chk("mrst_stall", 32'(stall_cnt), 32'd0);
    chk("mrst_jf", 32'(JumpFlush), 32'd0);
    chk("mrst_pc", ex_pc, 32'd0);
    id_valid = 1'b1; id_pc = 32'h80; IDEX_enable = 1'b1;
    step();
    clrIn();
    chk("post_valid", 32'(ex_valid), 32'd1);
    chk("post_pc", ex_pc, 32'h80);
    chk("post_jf", 32'(JumpFlush), 32'd0);

    // invalid advance yields a bubble
    id_valid = 1'b0; id_MemWrite = 1'b1; id_pc = 32'h84;
    id_RegWr = 1'b1; id_op = 6'h2B; IDEX_enable = 1'b1;
    step();
    clrIn();
    chk("inv_memwr", 32'(ex_MemWrite), 32'd0);
    chk("inv_valid", 32'(ex_valid), 32'd0);
    chk("inv_pc", ex_pc, 32'd0);
    chk("inv_op", 32'(ex_op), 32'd0);

    // saturation on the 4-bit instance
    id_valid = 1'b1; id_pc = 32'h90; IDEX_enable = 1'b1;
    step();
    clrIn();
    for (int i = 0; i < 20; i++) step();
    chk("sat_small", 32'(sStall), 32'd15);
    chk("sat_big", 32'(stall_cnt), 32'd20);
    chk("sat_pc", sPc, 32'h90);

    // reloaded jump pulses again
    id_valid = 1'b1; id_jump = 1'b1; IDEX_enable = 1'b1;
    step();
    clrIn();
    chk("rejmp_jf", 32'(JumpFlush), 32'd1);
    chk("rejmp_stall", 32'(stall_cnt), 32'd20);
    step();
    chk("rejmp_off", 32'(JumpFlush), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
